// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
// The master drives the request and the slave returns the handshake and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with a start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to make the sub input select a-b.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             ha0_s;
    logic             ha0_c;
    logic             ha1_c;
    logic             bit_s;
    logic             bit_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's complement: invert b and force the carry-in to 1.
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
    logic sub_unused;
    assign sub_unused = bus.sub;
    assign b_load     = bus.b;
    assign c_load     = bus.cin;
`endif

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    // Full adder cell as two half adders joined by an OR.
    assign ha0_s = a_sr[0] ^ b_sr[0];
    assign ha0_c = a_sr[0] & b_sr[0];
    assign bit_s = ha0_s ^ carry;
    assign ha1_c = ha0_s & carry;
    assign bit_c = ha0_c | ha1_c;

    always_comb begin
        res_nxt            = res_sr >> 1;
        res_nxt[WIDTH-1]   = bit_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            carry  <= bit_c;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum_q  <= res_nxt;
                cout_q <= bit_c;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, corner sequences and random operations
// checked against an arithmetic model of the serial adder.
module tb_serial_adder;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   overlap = 1'b0;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`endif
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s,
                          output int lat, output int nbusy);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
        bus.sub   = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        bus.sub   = 1'($urandom);
        lat   = 0;
        nbusy = 0;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic op_check(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic c,
                            input logic s, input logic [W-1:0] es,
                            input logic ec);
        int lat;
        int nb;
        run_op(a, b, c, s, lat, nb);
        chk({name, "_latency"}, 64'(lat), 64'(W + 1));
        chk({name, "_busy"}, 64'(nb), 64'(W));
        chk({name, "_sum"}, 64'(bus.sum), 64'(es));
        chk({name, "_cout"}, 64'(bus.cout), 64'(ec));
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        vec_t         tbl [8];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        logic [W:0]   exp;
        int           lat;
        int           nb;
        int           ndone;
        logic [W-1:0] got_sum;
        logic         got_cout;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        tbl[5] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1};
`ifdef SERIAL_ADDER_SUB_EN
        tbl[6] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
        tbl[7] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0};
`else
        tbl[6] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[7] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 1'b0};
`endif

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_sum", 64'(bus.sum), 64'(0));
        chk("reset_cout", 64'(bus.cout), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            op_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                     tbl[i].cin, tbl[i].sub, tbl[i].sum, tbl[i].cout);
        end

        // start during RUN must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone     = 0;
        got_sum   = '0;
        got_cout  = 1'b0;
        for (int i = 1; i <= W + 5; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                got_sum  = bus.sum;
                got_cout = bus.cout;
            end
            bus.start = (i == 3);
            if (i == 3) begin
                bus.a = 8'hFF;
                bus.b = 8'hFF;
            end
        end
        chk("ignore_done_count", 64'(ndone), 64'(1));
        chk("ignore_sum", 64'(got_sum), 64'(8'h46));
        chk("ignore_cout", 64'(got_cout), 64'(0));

        // reset mid-operation aborts without a done pulse
        op_check("pre_reset", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        chk("abort_sum", 64'(bus.sum), 64'(0));
        chk("abort_cout", 64'(bus.cout), 64'(0));
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'(0));
        op_check("post_reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

        // back-to-back: start held in the done cycle
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, nb);
        chk("b2b_first_lat", 64'(lat), 64'(W + 1));
        chk("b2b_first_sum", 64'(bus.sum), 64'(8'h96));
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        nb  = 0;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (i == 1) chk("b2b_rerun", 64'(bus.busy), 64'(1));
            if (i == 4) chk("b2b_sum_hold", 64'(bus.sum), 64'(8'h96));
            if (bus.busy) nb++;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_lat", 64'(lat), 64'(W + 1));
        chk("b2b_busy", 64'(nb), 64'(W));
        chk("b2b_sum", 64'(bus.sum), 64'(8'h00));
        chk("b2b_cout", 64'(bus.cout), 64'(1));

        for (int i = 0; i < 40; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            rs  = 1'($urandom);
            exp = model(ra, rb, rc, rs);
            op_check($sformatf("rand%0d", i), ra, rb, rc, rs,
                     exp[W-1:0], exp[W]);
        end

        chk("busy_done_overlap", 64'(overlap), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
